laser_safety_sequencer: RTL and testbench

- Controller and configurator for the laser pulse width/rate checker.
- Holds the four 32-bit limit registers that drive the checker, and accepts configuration writes only while disarmed.
- Sequences arm, armed, fault, clear and idle; gates the laser enable; drives the checker's clear_fail input.
- Latches a sticky fault code and keeps a saturating fault counter for the host.

---
 rtl/laser_safety_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_laser_safety_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_safety_sequencer.sv
// laser_safety_sequencer
//   Arms and disarms the laser, owns the four limit registers that feed the
//   pulse width/rate checker, and sequences fault capture and fault clearing.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   arm_req/disarm_req/clear_req  single-cycle host requests
//   cfg_wr/cfg_addr/cfg_wdata limit write port (0=PW_LO 1=PW_HI 2=RATE_LO 3=RATE_HI)
//   cfg_ack/cfg_err           single-cycle write-accepted / write-or-arm-rejected
//   laser_pulse, fail_flags   laser pulse and checker flags {rate_hi,rate_lo,pw_hi,pw_lo}
//   clear_fail                clear strobe to the checker
//   *_limit                   limit values to the checker
//   laser_en, armed, fault    status; fault_code {wdog, flags[3:0]}; fault_count (saturating)
module laser_safety_sequencer #(
  parameter logic [31:0] DEF_PW_LO    = 32'd10,
  parameter logic [31:0] DEF_PW_HI    = 32'd100,
  parameter logic [31:0] DEF_RATE_LO  = 32'd1000,
  parameter logic [31:0] DEF_RATE_HI  = 32'd100000,
  parameter int unsigned ARM_DELAY    = 16,
  parameter int unsigned CLEAR_CYCLES = 4,
  parameter logic [31:0] WDOG_CYCLES  = 32'd200000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        arm_req,
  input  logic        disarm_req,
  input  logic        clear_req,
  input  logic        cfg_wr,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic        cfg_ack,
  output logic        cfg_err,
  input  logic        laser_pulse,
  input  logic [3:0]  fail_flags,
  output logic        clear_fail,
  output logic [31:0] pw_lower_limit,
  output logic [31:0] pw_upper_limit,
  output logic [31:0] rate_lower_limit,
  output logic [31:0] rate_upper_limit,
  output logic        laser_en,
  output logic        armed,
  output logic        fault,
  output logic [4:0]  fault_code,
  output logic [15:0] fault_count
);
  // Purpose: arm/fault/clear sequencer plus limit register file for the pulse checker.
  // Latency: every output is registered; a sampled input is reflected one cycle later.
  // Backpressure: none; requests are single-cycle strobes answered by cfg_ack/cfg_err.

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMING,
    S_ARMED,
    S_FAULT,
    S_CLEARING
  } state_e;

  localparam logic [31:0]       ARM_LAST = 32'(ARM_DELAY - 1);
  localparam logic [31:0]       CLR_LEN  = 32'(CLEAR_CYCLES);
  localparam logic [3:0][31:0]  LIM_RST  = {DEF_RATE_HI, DEF_RATE_LO, DEF_PW_HI, DEF_PW_LO};

  state_e           state_q, state_d;
  logic [3:0][31:0] lim_q, lim_d;
  logic [31:0]      arm_cnt_q, arm_cnt_d;
  logic [31:0]      wdog_q, wdog_d;
  logic [31:0]      clr_left_q, clr_left_d;
  logic [4:0]       code_q, code_d;
  logic [15:0]      count_q, count_d;
  logic             pulse_d1_q;
  logic             laser_en_q, laser_en_d;
  logic             armed_q, armed_d;
  logic             fault_q, fault_d;
  logic             clear_fail_q, clear_fail_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic             pulse_rise;
  logic             flag_any;
  logic             wdog_exp;
  logic             limits_ok;
  logic             fault_entry;

  assign pulse_rise = laser_pulse & ~pulse_d1_q;
  assign flag_any   = |fail_flags;
  assign wdog_exp   = (wdog_q == WDOG_CYCLES);
  assign limits_ok  = (lim_q[0] <= lim_q[1]) && (lim_q[2] <= lim_q[3]);

  always_comb begin
    state_d     = state_q;
    lim_d       = lim_q;
    arm_cnt_d   = arm_cnt_q;
    wdog_d      = wdog_q;
    clr_left_d  = clr_left_q;
    code_d      = code_q;
    count_d     = count_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    fault_entry = 1'b0;

    // Limits are frozen whenever the laser path may be live.
    if (cfg_wr && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        // A write in the same cycle as an arm request swallows the arm silently.
        if (cfg_wr) begin
          lim_d[cfg_addr] = cfg_wdata;
          ack_d           = 1'b1;
        end else if (arm_req) begin
          if (limits_ok) begin
            state_d   = S_ARMING;
            arm_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_ARMING: begin
        if (flag_any) begin
          fault_entry = 1'b1;
          code_d      = code_q | {1'b0, fail_flags};
        end else if (disarm_req) begin
          state_d = S_IDLE;
        end else if (arm_cnt_q == ARM_LAST) begin
          state_d = S_ARMED;
          wdog_d  = '0;
        end else begin
          arm_cnt_d = arm_cnt_q + 32'd1;
        end
      end

      S_ARMED: begin
        // Fault beats disarm so a coincident disarm cannot hide the event.
        if (flag_any || wdog_exp) begin
          fault_entry = 1'b1;
          code_d      = code_q | {wdog_exp, fail_flags};
        end else if (disarm_req) begin
          state_d = S_IDLE;
        end else if (pulse_rise) begin
          wdog_d = '0;
        end else if (!wdog_exp) begin
          wdog_d = wdog_q + 32'd1;
        end
      end

      S_FAULT: begin
        code_d[3:0] = code_q[3:0] | fail_flags;
        if (clear_req) begin
          state_d    = S_CLEARING;
          clr_left_d = CLR_LEN;
        end
      end

      S_CLEARING: begin
        // Leave only once the strobe has finished and the checker reports clean.
        if ((clr_left_q == '0) && !flag_any) begin
          state_d = S_IDLE;
          code_d  = '0;
        end else if (clear_req) begin
          clr_left_d = CLR_LEN;
        end else if (clr_left_q != '0) begin
          clr_left_d = clr_left_q - 32'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (fault_entry) begin
      state_d = S_FAULT;
      count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    end

    laser_en_d   = (state_d == S_ARMED);
    armed_d      = (state_d == S_ARMED);
    fault_d      = (state_d == S_FAULT) || (state_d == S_CLEARING);
    clear_fail_d = (state_d == S_CLEARING) && (clr_left_d != '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      lim_q        <= LIM_RST;
      arm_cnt_q    <= '0;
      wdog_q       <= '0;
      clr_left_q   <= '0;
      code_q       <= '0;
      count_q      <= '0;
      pulse_d1_q   <= 1'b0;
      laser_en_q   <= 1'b0;
      armed_q      <= 1'b0;
      fault_q      <= 1'b0;
      clear_fail_q <= 1'b0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lim_q        <= lim_d;
      arm_cnt_q    <= arm_cnt_d;
      wdog_q       <= wdog_d;
      clr_left_q   <= clr_left_d;
      code_q       <= code_d;
      count_q      <= count_d;
      pulse_d1_q   <= laser_pulse;
      laser_en_q   <= laser_en_d;
      armed_q      <= armed_d;
      fault_q      <= fault_d;
      clear_fail_q <= clear_fail_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
    end
  end

  assign pw_lower_limit   = lim_q[0];
  assign pw_upper_limit   = lim_q[1];
  assign rate_lower_limit = lim_q[2];
  assign rate_upper_limit = lim_q[3];
  assign laser_en         = laser_en_q;
  assign armed            = armed_q;
  assign fault            = fault_q;
  assign clear_fail       = clear_fail_q;
  assign cfg_ack          = ack_q;
  assign cfg_err          = err_q;
  assign fault_code       = code_q;
  assign fault_count      = count_q;

endmodule

// File: tb/tb_laser_safety_sequencer.sv
// tb_laser_safety_sequencer
//   Self-checking bench: a table of directed configuration vectors, hand-written
//   arm/fault/watchdog/reset sequences, and random traffic against a timestamp model.
module tb_laser_safety_sequencer;
  localparam int          ARM_DELAY    = 16;
  localparam int          CLEAR_CYCLES = 4;
  localparam int          WDOG         = 6000;
  localparam logic [31:0] D_PW_LO      = 32'd10;
  localparam logic [31:0] D_PW_HI      = 32'd100;
  localparam logic [31:0] D_RATE_LO    = 32'd1000;
  localparam logic [31:0] D_RATE_HI    = 32'd100000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        arm_req, disarm_req, clear_req, cfg_wr;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_ack, cfg_err;
  logic        laser_pulse;
  logic [3:0]  fail_flags;
  logic        clear_fail;
  logic [31:0] pw_lower_limit, pw_upper_limit, rate_lower_limit, rate_upper_limit;
  logic        laser_en, armed, fault;
  logic [4:0]  fault_code;
  logic [15:0] fault_count;

  laser_safety_sequencer #(
    .DEF_PW_LO(D_PW_LO), .DEF_PW_HI(D_PW_HI), .DEF_RATE_LO(D_RATE_LO), .DEF_RATE_HI(D_RATE_HI),
    .ARM_DELAY(ARM_DELAY), .CLEAR_CYCLES(CLEAR_CYCLES), .WDOG_CYCLES(32'(WDOG))
  ) dut (
    .clk(clk), .rstn(rstn), .arm_req(arm_req), .disarm_req(disarm_req), .clear_req(clear_req),
    .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .laser_pulse(laser_pulse), .fail_flags(fail_flags), .clear_fail(clear_fail),
    .pw_lower_limit(pw_lower_limit), .pw_upper_limit(pw_upper_limit),
    .rate_lower_limit(rate_lower_limit), .rate_upper_limit(rate_upper_limit),
    .laser_en(laser_en), .armed(armed), .fault(fault), .fault_code(fault_code), .fault_count(fault_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (phases + timestamps) ----------------
  string       m_ph;
  longint      m_cyc = 0;
  longint      m_t_arm, m_t_ref, m_t_clr;
  int unsigned m_lim [4];
  bit [4:0]    m_code;
  int          m_cnt;
  bit          m_prev;
  bit          m_laser, m_armed, m_fault, m_clr, m_ack, m_err;

  task automatic model_reset();
    m_lim[0] = D_PW_LO; m_lim[1] = D_PW_HI; m_lim[2] = D_RATE_LO; m_lim[3] = D_RATE_HI;
    m_ph = "IDLE"; m_code = '0; m_cnt = 0; m_prev = 0;
    m_laser = 0; m_armed = 0; m_fault = 0; m_clr = 0; m_ack = 0; m_err = 0;
  endtask

  task automatic model_fault(input bit [4:0] bits);
    m_ph   = "FAULT";
    m_code = m_code | bits;
    if (m_cnt != 65535) m_cnt++;
  endtask

  task automatic model_edge();
    bit rise, any, expired;
    m_cyc++;
    m_ack = 0; m_err = 0;
    rise    = laser_pulse && !m_prev;
    any     = (fail_flags != 4'd0);
    expired = (m_ph == "ARMED") && ((m_cyc - m_t_ref) > WDOG);
    if (cfg_wr && m_ph != "IDLE") m_err = 1;
    if (m_ph == "IDLE") begin
      if (cfg_wr) begin
        m_lim[cfg_addr] = cfg_wdata;
        m_ack = 1;
      end else if (arm_req) begin
        if (m_lim[0] <= m_lim[1] && m_lim[2] <= m_lim[3]) begin
          m_ph = "ARMING"; m_t_arm = m_cyc;
        end else m_err = 1;
      end
    end else if (m_ph == "ARMING") begin
      if (any) model_fault({1'b0, fail_flags});
      else if (disarm_req) m_ph = "IDLE";
      else if (m_cyc - m_t_arm == ARM_DELAY) begin m_ph = "ARMED"; m_t_ref = m_cyc; end
    end else if (m_ph == "ARMED") begin
      if (any || expired) model_fault({expired, fail_flags});
      else if (disarm_req) m_ph = "IDLE";
      else if (rise) m_t_ref = m_cyc;
    end else if (m_ph == "FAULT") begin
      m_code[3:0] = m_code[3:0] | fail_flags;
      if (clear_req) begin m_ph = "CLEARING"; m_t_clr = m_cyc; end
    end else if (m_ph == "CLEARING") begin
      if ((m_cyc - m_t_clr) > CLEAR_CYCLES && !any) begin m_ph = "IDLE"; m_code = '0; end
      else if (clear_req) m_t_clr = m_cyc;
    end
    m_laser = (m_ph == "ARMED");
    m_armed = (m_ph == "ARMED");
    m_fault = (m_ph == "FAULT") || (m_ph == "CLEARING");
    m_clr   = (m_ph == "CLEARING") && ((m_cyc - m_t_clr) < CLEAR_CYCLES);
    m_prev  = laser_pulse;
  endtask

  task automatic compare_model();
    chk("status{en,armed,fault,clr,ack,err}",
        128'({laser_en, armed, fault, clear_fail, cfg_ack, cfg_err}),
        128'({m_laser, m_armed, m_fault, m_clr, m_ack, m_err}));
    chk("fault_code", 128'(fault_code), 128'(m_code));
    chk("fault_count", 128'(fault_count), 128'(m_cnt));
    chk("limits", {rate_upper_limit, rate_lower_limit, pw_upper_limit, pw_lower_limit},
        {m_lim[3], m_lim[2], m_lim[1], m_lim[0]});
  endtask

  task automatic step(input bit a, input bit d, input bit c, input bit w, input bit [1:0] ad,
                      input bit [31:0] wd, input bit [3:0] fl, input bit pl);
    arm_req = a; disarm_req = d; clear_req = c; cfg_wr = w;
    cfg_addr = ad; cfg_wdata = wd; fail_flags = fl; laser_pulse = pl;
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic idle(input int n, input bit [3:0] fl);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 2'd0, 32'd0, fl, 0);
  endtask

  // Arm and count cycles (arm cycle included) until laser_en is seen.
  task automatic arm_and_wait(input string tag);
    int lat;
    lat = 1;
    step(1, 0, 0, 0, 2'd0, 32'd0, 4'd0, 0);
    while (laser_en !== 1'b1 && lat < ARM_DELAY + 8) begin
      idle(1, 4'd0);
      lat++;
    end
    chk(tag, 128'(lat), 128'(ARM_DELAY + 1));
  endtask

  typedef struct {
    bit        arm, disarm, clr, wr;
    bit [1:0]  addr;
    bit [31:0] wd;
    bit [3:0]  fl;
    bit        pl;
    bit [3:0]  e_st;    // {laser_en, cfg_ack, cfg_err, fault}
    bit [4:0]  e_code;
  } vec_t;

  vec_t tv [12];

  initial begin
    int hi_cnt;
    int waited;

    tv[0]  = '{0,0,0,1,2'd1,32'd200,   4'd0,0,4'b0100,5'd0};  // write PW_HI=200
    tv[1]  = '{0,0,0,0,2'd0,32'd0,     4'd0,0,4'b0000,5'd0};
    tv[2]  = '{0,0,0,1,2'd0,32'd300,   4'd0,0,4'b0100,5'd0};  // PW_LO=300 > PW_HI
    tv[3]  = '{1,0,0,0,2'd0,32'd0,     4'd0,0,4'b0010,5'd0};  // arm rejected
    tv[4]  = '{0,0,0,0,2'd0,32'd0,     4'd0,0,4'b0000,5'd0};
    tv[5]  = '{0,0,0,1,2'd0,32'd10,    4'd0,0,4'b0100,5'd0};  // PW_LO=10
    tv[6]  = '{1,0,0,1,2'd3,32'd100000,4'd0,0,4'b0100,5'd0};  // write wins over arm
    tv[7]  = '{0,1,0,0,2'd0,32'd0,     4'd0,0,4'b0000,5'd0};  // disarm in IDLE ignored
    tv[8]  = '{1,0,0,0,2'd0,32'd0,     4'd0,0,4'b0000,5'd0};  // arm accepted -> ARMING
    tv[9]  = '{0,0,0,1,2'd1,32'd7,     4'd0,0,4'b0010,5'd0};  // write while ARMING rejected
    tv[10] = '{0,1,0,0,2'd0,32'd0,     4'd0,0,4'b0000,5'd0};  // disarm -> IDLE
    tv[11] = '{0,0,0,1,2'd2,32'd2000,  4'd0,0,4'b0100,5'd0};  // RATE_LO=2000

    rstn = 0; arm_req = 0; disarm_req = 0; clear_req = 0; cfg_wr = 0;
    cfg_addr = 0; cfg_wdata = 0; fail_flags = 0; laser_pulse = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    chk("reset_status", 128'({laser_en, armed, fault, clear_fail, cfg_ack, cfg_err}), 128'(0));
    chk("reset_code_count", 128'({fault_code, fault_count}), 128'(0));
    compare_model();

    // ---- directed configuration table ----
    for (int i = 0; i < 12; i++) begin
      step(tv[i].arm, tv[i].disarm, tv[i].clr, tv[i].wr, tv[i].addr, tv[i].wd, tv[i].fl, tv[i].pl);
      chk($sformatf("vec%0d_status", i), 128'({laser_en, cfg_ack, cfg_err, fault}), 128'(tv[i].e_st));
      chk($sformatf("vec%0d_code", i), 128'(fault_code), 128'(tv[i].e_code));
    end
    chk("limits_after_table", {rate_upper_limit, rate_lower_limit, pw_upper_limit, pw_lower_limit},
        {32'd100000, 32'd2000, 32'd200, 32'd10});

    // ---- arm latency, write while armed, steady pulses ----
    arm_and_wait("arm_latency");
    step(0, 0, 0, 1, 2'd1, 32'd999, 4'd0, 0);
    chk("armed_wr_err", 128'({cfg_ack, cfg_err}), 128'(2'b01));
    chk("armed_wr_unchanged", 128'(pw_upper_limit), 128'(200));
    for (int p = 0; p < 10; p++) begin
      step(0, 0, 0, 0, 2'd0, 32'd0, 4'd0, 1);
      idle(4999, 4'd0);
    end
    chk("pulses_no_fault", 128'({laser_en, armed, fault}), 128'(3'b110));

    // ---- checker flag fault and clear handshake ----
    step(0, 0, 0, 0, 2'd0, 32'd0, 4'b0010, 0);
    chk("flag_fault_status", 128'({laser_en, fault}), 128'(2'b01));
    chk("flag_fault_code", 128'(fault_code), 128'(5'b00010));
    chk("flag_fault_count", 128'(fault_count), 128'(1));
    step(1, 1, 0, 0, 2'd0, 32'd0, 4'b0110, 0);
    chk("fault_or_flags", 128'({fault, laser_en, fault_code}), 128'({1'b1, 1'b0, 5'b00110}));
    step(0, 0, 1, 0, 2'd0, 32'd0, 4'b0110, 0);
    hi_cnt = clear_fail ? 1 : 0;
    for (int k = 0; k < 10; k++) begin
      idle(1, 4'b0110);
      if (clear_fail === 1'b1) hi_cnt++;
    end
    chk("clear_fail_len", 128'(hi_cnt), 128'(CLEAR_CYCLES));
    chk("clearing_holds", 128'(fault), 128'(1));
    waited = 0;
    do begin
      idle(1, 4'd0);
      waited++;
    end while (fault !== 1'b0 && waited < 10);
    chk("cleared_idle", 128'({fault, fault_code}), 128'(0));

    // ---- watchdog expiry coincident with disarm ----
    arm_and_wait("arm_latency_2");
    idle(WDOG, 4'd0);
    chk("wdog_still_armed", 128'(laser_en), 128'(1));
    step(0, 1, 0, 0, 2'd0, 32'd0, 4'd0, 0);
    chk("wdog_fault_status", 128'({laser_en, fault}), 128'(2'b01));
    chk("wdog_fault_code", 128'(fault_code), 128'(5'b10000));
    chk("wdog_fault_count", 128'(fault_count), 128'(2));
    step(0, 0, 1, 0, 2'd0, 32'd0, 4'd0, 0);
    idle(CLEAR_CYCLES + 2, 4'd0);
    chk("wdog_cleared", 128'({fault, fault_code}), 128'(0));

    // ---- asynchronous reset while armed ----
    arm_and_wait("arm_latency_3");
    #2 rstn = 0;
    #1;
    chk("async_laser_off", 128'({laser_en, armed}), 128'(0));
    chk("reset_limits", {rate_upper_limit, rate_lower_limit, pw_upper_limit, pw_lower_limit},
        {D_RATE_HI, D_RATE_LO, D_PW_HI, D_PW_LO});
    chk("reset_count", 128'(fault_count), 128'(0));
    model_reset();
    arm_req = 0; disarm_req = 0; clear_req = 0; cfg_wr = 0; fail_flags = 0; laser_pulse = 0;
    @(posedge clk);
    #1 rstn = 1;

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 4000; i++) begin
      bit a, d, c, w, pl;
      bit [1:0]  ad;
      bit [31:0] wd;
      bit [3:0]  fl;
      a  = ($urandom_range(0, 19) == 0);
      d  = ($urandom_range(0, 99) == 0);
      c  = ($urandom_range(0, 29) == 0);
      w  = ($urandom_range(0, 39) == 0);
      ad = 2'($urandom_range(0, 3));
      wd = ad[0] ? 32'($urandom_range(500, 200000)) : 32'($urandom_range(0, 1000));
      fl = ($urandom_range(0, 149) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      pl = ($urandom_range(0, 3) == 0);
      step(a, d, c, w, ad, wd, fl, pl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
